pll_lock_rstgen: RTL and testbench



---
 rtl/pll_lock_rstgen_pkg.sv | 15 +
 rtl/lock_sync.sv | 24 ++
 rtl/pll_lock_rstgen.sv | 144 ++++++++++++++
 tb/tb_pll_lock_rstgen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_rstgen_pkg.sv
// rtl/pll_lock_rstgen_pkg.sv - shared types and constants for the PLL lock reset sequencer
package pll_lock_rstgen_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam int LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/lock_sync.sv
// rtl/lock_sync.sv - reusable multi-flop synchronizer for an asynchronous level input
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] chain;

  // shift the async level through STAGES flops; reset clears the chain to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_rstgen.sv
// rtl/pll_lock_rstgen.sv - PLL enable / lock qualification / system reset sequencer (optional LOCK_TIMEOUT_EN)
module pll_lock_rstgen
  import pll_lock_rstgen_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int OFF_CYCLES     = 64,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 17
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pll_lock,
  output logic                  pll_en,
  output logic                  sys_rstn,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic                  timeout
);

  localparam logic [CNT_W-1:0] OFF_LAST    = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [LOSS_CNT_W-1:0]   loss_nxt;
  logic                    lock_s;

  lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .din   (pll_lock),
    .dout  (lock_s)
  );

`ifdef LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tcnt;
  logic             timeout_hit;

  // acquisition gives up only while actively waiting for or qualifying lock
  assign timeout_hit = ((state == WAIT_LOCK) || (state == STABLE)) && (tcnt == TIMEOUT_LAST);

  // acquisition timer: cleared whenever the PLL is power-cycled or lock is accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      if (timeout_hit) begin
        timeout <= 1'b1;
      end
      if ((state_nxt == OFF) || (state_nxt == RUN)) begin
        tcnt <= '0;
      end else if ((state == WAIT_LOCK) || (state == STABLE)) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // next-state logic; the shared counter restarts on every state change
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    loss_nxt  = lock_loss_cnt;
    case (state)
      OFF: begin
        if (cnt == OFF_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) begin
          state_nxt = STABLE;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          if (lock_loss_cnt != LOSS_CNT_MAX) begin
            loss_nxt = lock_loss_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = OFF;
        cnt_nxt   = '0;
      end
    endcase
`ifdef LOCK_TIMEOUT_EN
    if (timeout_hit) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
    end
`endif
  end

  // state, counter and outputs registered together so outputs track the new state on the same edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= OFF;
      cnt           <= '0;
      pll_en        <= 1'b0;
      sys_rstn      <= 1'b0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      pll_en        <= (state_nxt != OFF);
      sys_rstn      <= (state_nxt == RUN);
      ready         <= (state_nxt == RUN);
      lock_loss_cnt <= loss_nxt;
    end
  end

endmodule

// File: tb/tb_pll_lock_rstgen.sv
// tb/tb_pll_lock_rstgen.sv - randomized self-checking bench for pll_lock_rstgen against a behavioural model
module tb_pll_lock_rstgen;

  localparam int SYNC  = 2;
  localparam int OFFC  = 4;
  localparam int STAB  = 8;
  localparam int HOLDC = 4;
  localparam int TO    = 32;
  localparam int CW    = 17;
  localparam int QUAL_DONE = 1 + STAB + HOLDC;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_lock;
  logic       pll_en, sys_rstn, ready, timeout;
  logic [7:0] lock_loss_cnt;

  always #5 clk = ~clk;

  pll_lock_rstgen #(
    .SYNC_STAGES   (SYNC),
    .OFF_CYCLES    (OFFC),
    .STABLE_CYCLES (STAB),
    .HOLD_CYCLES   (HOLDC),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pll_lock     (pll_lock),
    .pll_en       (pll_en),
    .sys_rstn     (sys_rstn),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .timeout      (timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Model: phase 0 = PLL powered off, 1 = acquiring, 2 = running.
  // Release happens after QUAL_DONE consecutive edges that see synchronized lock high.
  int m_phase, m_off_n, m_qual, m_tcnt, m_loss;
  bit m_to;
  bit m_hist [SYNC];

  task automatic model_reset();
    m_phase = 0; m_off_n = 0; m_qual = 0; m_tcnt = 0; m_loss = 0; m_to = 0;
    for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
  endtask

  task automatic model_edge(input bit lk);
    bit ls, ticking, fired;
    ls = m_hist[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = lk;
    fired = 0;
    case (m_phase)
      0: begin
        if (m_off_n == OFFC - 1) begin m_phase = 1; m_off_n = 0; m_qual = 0; end
        else m_off_n++;
      end
      1: begin
        ticking = (m_qual < 1 + STAB);
`ifdef LOCK_TIMEOUT_EN
        if (ticking && m_tcnt == TO - 1) begin
          m_to = 1; m_tcnt = 0; m_phase = 0; m_off_n = 0; m_qual = 0; fired = 1;
        end
`endif
        if (!fired) begin
          if (ticking) m_tcnt++;
          if (!ls) m_qual = 0;
          else begin
            m_qual++;
            if (m_qual == QUAL_DONE) begin m_phase = 2; m_tcnt = 0; end
          end
        end
      end
      default: begin
        if (!ls) begin
          m_phase = 1; m_qual = 0;
          if (m_loss < 255) m_loss++;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("pll_en",   pll_en,   (m_phase != 0));
    check("sys_rstn", sys_rstn, (m_phase == 2));
    check("ready",    ready,    (m_phase == 2));
    check("loss_cnt", lock_loss_cnt, m_loss);
    check("timeout",  timeout,  m_to);
  endtask

  // one clock: drive at negedge, model steps on the edge, compare at next negedge
  task automatic cyc(input bit lk);
    pll_lock = lk;
    @(posedge clk);
    if (resetn) model_edge(lk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int n;
    int r, len;
    bit hit;
    resetn   = 1'b0;
    pll_lock = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    check("rst_pll_en", pll_en, 0);

    // power-up: pll_en rises on the 4th edge after release
    resetn = 1'b1;
    n = 0;
    do begin cyc(0); n++; end while (!pll_en && n < 20);
    check("pll_en_lat", n, OFFC);
    repeat (3) cyc(0);

    // lock rise to release latency
    cyc(1);
    n = 0;
    do begin cyc(1); n++; end while (!sys_rstn && n < 100);
    check("rise_lat", n, SYNC + STAB + HOLDC);
    repeat (3) cyc(1);

    // single-cycle drop in RUN
    cyc(0);
    n = 1;
    while (sys_rstn && n < 20) begin cyc(1); n++; end
    check("fall_lat", n, SYNC + 1);
    check("loss_one", lock_loss_cnt, 1);
    repeat (30) cyc(1);
    check("requal", sys_rstn, 1);

    // short pulses during qualification must not count as losses
    repeat (3) cyc(0);
    repeat (5) cyc(1);
    repeat (2) cyc(0);
    repeat (6) cyc(1);
    cyc(0);
    repeat (30) cyc(1);
    check("glitch_loss", lock_loss_cnt, 2);

    // randomized lock waveforms
    for (int s = 0; s < 150; s++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: begin len = $urandom_range(10, 40); repeat (len) cyc(1); end
        1: begin len = $urandom_range(1, 3);   repeat (len) cyc(0); end
        2: begin len = $urandom_range(1, 12);  repeat (len) cyc(1); end
        default: begin len = $urandom_range(5, 20); repeat (len) cyc(0); end
      endcase
    end

    // saturation of the loss counter
    n = 0;
    while (!sys_rstn && n < 200) begin cyc(1); n++; end
    for (int k = 0; k < 270; k++) begin
      repeat (18) cyc(1);
      cyc(0);
    end
    repeat (20) cyc(1);
    check("loss_sat", lock_loss_cnt, 255);

    // async reset while in HOLD
    cyc(0);
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      cyc(1);
      hit = (m_phase == 1 && m_qual >= 1 + STAB + 1);
    end
    check("hold_reached", hit, 1);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check("arst_pll_en", pll_en, 0);
    check("arst_sys_rstn", sys_rstn, 0);
    check("arst_ready", ready, 0);
    check("arst_loss", lock_loss_cnt, 0);
    check("arst_timeout", timeout, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (OFFC - 1) cyc(1);
    check("restart_off", pll_en, 0);
    cyc(1);
    check("restart_en", pll_en, 1);
    repeat (30) cyc(1);

`ifdef LOCK_TIMEOUT_EN
    repeat (200) cyc(0);
    check("timeout_set", timeout, 1);
    repeat (60) cyc(1);
    check("timeout_sticky", timeout, 1);
`else
    repeat (200) cyc(0);
    check("timeout_off", timeout, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
